// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM read arbiter.
// A grant record travels down the ROM-latency pipeline alongside each read.
package rom_arb_pkg;

    localparam int unsigned ROM_WORD_BITS = 256;
    localparam int unsigned BYTE_SEL_W    = 5;
    localparam int unsigned ID_W          = 3;

    typedef struct packed {
        logic                  valid;
        logic [ID_W-1:0]       id;
        logic [BYTE_SEL_W-1:0] byte_sel;
    } rom_grant_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible client at or after rr_ptr, circularly.
// The pointer register lives in the instantiating module.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [PTR_W-1:0]   grant_id_c,
    output logic               any_c
);

    // Pass one covers [rr_ptr, NUM_REQ), pass two wraps to [0, rr_ptr).
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        any_c      = 1'b0;
        for (int c = 0; c < int'(NUM_REQ); c++) begin
            if (!any_c && eligible[c] && (PTR_W'(c) >= rr_ptr)) begin
                grant_c[c] = 1'b1;
                grant_id_c = PTR_W'(c);
                any_c      = 1'b1;
            end
        end
        for (int c = 0; c < int'(NUM_REQ); c++) begin
            if (!any_c && eligible[c] && (PTR_W'(c) < rr_ptr)) begin
                grant_c[c] = 1'b1;
                grant_id_c = PTR_W'(c);
                any_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one 256-bit ROM read port between NUM_REQ byte-read clients with round-robin
// fairness; one grant per cycle, one outstanding read per client.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned ROM_LATENCY = 2
) (
    input  logic                        CLK_50Mhz,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*16-1:0]       req_index,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_base,
    output logic [NUM_REQ*8-1:0]        data_out,
    output logic [NUM_REQ-1:0]          data_valid,
    output logic [ADDR_W-BYTE_SEL_W-1:0] rom_address,
    input  logic [ROM_WORD_BITS-1:0]    rom_q,
    output logic                        busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned IDX_W = 16;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_nxt_c;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] pending_nxt_c;
    logic [NUM_REQ-1:0] eligible_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [NUM_REQ-1:0] retire_c;
    logic [PTR_W-1:0]   grant_id_c;
    logic               any_c;
    logic [ADDR_W-1:0]  base_c;
    logic [IDX_W-1:0]   index_c;
    logic [ADDR_W-1:0]  addr_c;
    rom_grant_t         pipe [ROM_LATENCY];
    rom_grant_t         tail;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .eligible   (eligible_c),
        .rr_ptr     (rr_ptr),
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c),
        .any_c      (any_c)
    );

    assign tail = pipe[ROM_LATENCY-1];

    // Eligibility, address of the winner, and pending bookkeeping.
    always_comb begin
        eligible_c = req & ~pending;
        base_c     = '0;
        index_c    = '0;
        retire_c   = '0;
        for (int c = 0; c < int'(NUM_REQ); c++) begin
            if (grant_c[c]) begin
                base_c  = req_base[c*ADDR_W +: ADDR_W];
                index_c = req_index[c*IDX_W +: IDX_W];
            end
            retire_c[c] = tail.valid && (tail.id == ID_W'(c));
        end
        addr_c        = base_c + ADDR_W'(index_c);
        pending_nxt_c = (pending | grant_c) & ~retire_c;
        ptr_nxt_c     = (grant_id_c == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(grant_id_c + PTR_W'(1));
    end

    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            rr_ptr      <= '0;
            pending     <= '0;
            rom_address <= '0;
            data_out    <= '0;
            data_valid  <= '0;
            for (int i = 0; i < int'(ROM_LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pending <= pending_nxt_c;
            if (any_c) begin
                rr_ptr      <= ptr_nxt_c;
                rom_address <= addr_c[ADDR_W-1:BYTE_SEL_W];
            end
            pipe[0].valid    <= any_c;
            pipe[0].id       <= ID_W'(grant_id_c);
            pipe[0].byte_sel <= addr_c[BYTE_SEL_W-1:0];
            for (int i = 1; i < int'(ROM_LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
            // ROM word is valid as the grant reaches the pipeline tail.
            for (int c = 0; c < int'(NUM_REQ); c++) begin
                data_valid[c] <= retire_c[c];
                if (retire_c[c]) begin
                    data_out[c*8 +: 8] <= rom_q[{tail.byte_sel, 3'b000} +: 8];
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(ROM_LATENCY); i++) begin
            busy = busy | pipe[i].valid;
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: directed scenarios plus random traffic,
// compared every cycle against a request-level reference model.
module tb_rom_read_arbiter;

    localparam int unsigned N   = 3;
    localparam int unsigned AW  = 21;
    localparam int unsigned LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*16-1:0]   req_index;
    logic [N*AW-1:0]   req_base;
    logic [N*8-1:0]    data_out;
    logic [N-1:0]      data_valid;
    logic [AW-6:0]     rom_address;
    logic [255:0]      rom_q;
    logic              busy;

    always #5 clk = ~clk;

    rom_read_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .ROM_LATENCY (LAT)
    ) dut (
        .CLK_50Mhz   (clk),
        .reset       (reset),
        .req         (req),
        .req_index   (req_index),
        .req_base    (req_base),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .busy        (busy)
    );

    logic [31:0] seed;

    function automatic logic [7:0] rom_byte(input logic [15:0] w, input logic [4:0] b);
        logic [31:0] h;
        h = {16'h0, w} * 32'h9E3779B1 + {27'h0, b} * 32'h85EBCA6B + seed;
        h = h ^ (h >> 15);
        return h[7:0];
    endfunction

    function automatic logic [255:0] rom_word(input logic [15:0] w);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[b*8 +: 8] = rom_byte(w, 5'(b));
        return r;
    endfunction

    // ROM macro: registered address plus registered output.
    always @(posedge clk) rom_q <= rom_word(rom_address);

    typedef struct {
        int         due;
        int         id;
        logic [7:0] val;
    } exp_t;

    exp_t          q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            m_ptr = 0;
    int            vcount[N];
    logic [N-1:0]  m_pend = '0;
    logic [AW-6:0] m_addr = '0;
    logic [N*8-1:0] exp_do = '0;
    logic [N-1:0]  exp_dv;
    logic          exp_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pick the winner from the spec rules and schedule its delivery.
    task automatic model_grant(inout logic [AW-6:0] an);
        int g;
        logic [AW-1:0] a;
        g = -1;
        for (int k = 0; k < int'(N); k++) begin
            int i;
            i = (m_ptr + k) % int'(N);
            if (g < 0 && req[i] && !m_pend[i]) g = i;
        end
        if (g >= 0) begin
            a = req_base[g*AW +: AW] + AW'(req_index[g*16 +: 16]);
            m_pend[g] = 1'b1;
            m_ptr = (g + 1) % int'(N);
            an = a[AW-1:5];
            q.push_back('{cyc + int'(LAT) + 1, g, rom_byte(a[AW-1:5], a[4:0])});
        end
    endtask

    task automatic tick();
        logic [AW-6:0] an;
        an = m_addr;
        if (!reset) model_grant(an);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        exp_dv = '0;
        if (reset) begin
            q.delete();
            m_pend = '0;
            m_ptr = 0;
            an = '0;
            exp_do = '0;
        end else begin
            while (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                exp_dv[e.id] = 1'b1;
                exp_do[e.id*8 +: 8] = e.val;
                m_pend[e.id] = 1'b0;
                vcount[e.id]++;
            end
        end
        m_addr = an;
        exp_busy = 1'b0;
        foreach (q[j]) if (q[j].due <= cyc + int'(LAT)) exp_busy = 1'b1;
        check("data_valid", 64'(data_valid), 64'(exp_dv));
        check("data_out", 64'(data_out), 64'(exp_do));
        check("rom_address", 64'(rom_address), 64'(m_addr));
        check("busy", 64'(busy), 64'(exp_busy));
    endtask

    initial begin
        int total;
        seed = $urandom;
        foreach (vcount[i]) vcount[i] = 0;
        reset = 1'b1;
        req = '1;
        req_index = {$urandom, $urandom};
        req_base = {$urandom, $urandom};

        // Reset held with all requests high.
        repeat (3) tick();
        reset = 1'b0;
        req = '0;
        tick();

        // Single read from client 0.
        req_base[0 +: AW] = 21'h1FBE7;
        req_index[0 +: 16] = 16'd5;
        req = 3'b001;
        tick();
        req = '0;
        check("t2_rom_address", 64'(rom_address), 64'h0FDF);
        tick();
        tick();
        check("t2_valid", 64'(data_valid), 64'b001);
        check("t2_byte", 64'(data_out[7:0]), 64'(rom_byte(16'h0FDF, 5'd12)));

        // All clients streaming.
        foreach (vcount[i]) vcount[i] = 0;
        req = '1;
        repeat (30) begin
            req_index = {$urandom, $urandom};
            tick();
        end
        req = '0;
        repeat (4) tick();
        for (int i = 0; i < int'(N); i++) check("t3_count_ge7", 64'(vcount[i] >= 7), 64'd1);

        // Address wrap.
        req_base[2*AW +: AW] = 21'h1FFFFF;
        req_index[2*16 +: 16] = 16'd2;
        req = 3'b100;
        tick();
        req = '0;
        check("t4_rom_address", 64'(rom_address), 64'h0);
        tick();
        tick();
        check("t4_valid", 64'(data_valid), 64'b100);
        check("t4_byte", 64'(data_out[23:16]), 64'(rom_byte(16'h0, 5'd1)));

        // Request dropped right after its grant.
        req = 3'b010;
        tick();
        req = '0;
        vcount[1] = 0;
        repeat (6) tick();
        check("t5_single_pulse", 64'(vcount[1]), 64'd1);

        // Reset with two reads in flight.
        req = 3'b011;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = '0;
        foreach (vcount[i]) vcount[i] = 0;
        repeat (5) tick();
        total = vcount[0] + vcount[1] + vcount[2];
        check("t6_no_valid", 64'(total), 64'd0);
        req = '1;
        repeat (3) tick();
        check("t6_first_client0", 64'(data_valid), 64'b001);

        // Random traffic with occasional resets.
        repeat (300) begin
            req = N'($urandom);
            req_index = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) req_base = {$urandom, $urandom};
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        req = '0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
